// File: rtl/column_buf_pkg.sv
// ---------------------------------------------------------------------------
// column_buf_pkg
// Shared types and constants for the column frame buffer.
//   buf_idx_t         : index of one of the three column banks
//   ADDR_*            : Avalon register map (DATA / CTRL / STATUS)
//   CTRL_*_BIT        : CTRL register bit positions
//   ST_*              : STATUS register field positions
//   third_buf(a, b)   : the bank index that is neither a nor b
// ---------------------------------------------------------------------------
package column_buf_pkg;

   typedef logic [1:0] buf_idx_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;

   localparam int CTRL_RESYNC_BIT  = 0;
   localparam int CTRL_CLRDROP_BIT = 1;

   // STATUS = {drop_cnt[7:0], pending, rd_frame_valid, word_idx[1:0], 4'b0}
   localparam int ST_DROP_LSB    = 8;
   localparam int ST_PENDING_BIT = 7;
   localparam int ST_VALID_BIT   = 6;
   localparam int ST_WIDX_LSB    = 4;

   // With indices 0,1,2 the XOR of all three is 2'b11, so the missing one
   // falls out of a single XOR.
   function automatic buf_idx_t third_buf(input buf_idx_t a, input buf_idx_t b);
      return 2'b11 ^ a ^ b;
   endfunction

endpackage

// File: rtl/column_bank.sv
// ---------------------------------------------------------------------------
// column_bank
// NUM_COLS x COL_BITS simple dual-port RAM: one write port, one registered
// read port. Contents are not reset.
//   clk    in  : clock
//   we     in  : write enable
//   waddr  in  : write column
//   wdata  in  : write entry
//   re     in  : read enable (read register holds when low)
//   raddr  in  : read column, must be < NUM_COLS
//   rdata  out : registered read entry
// ---------------------------------------------------------------------------
module column_bank #(
   parameter int NUM_COLS = 640,
   parameter int COL_BITS = 64,
   parameter int ADDR_W   = 10
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [COL_BITS-1:0] wdata,
   input  logic                re,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [COL_BITS-1:0] rdata
);

   logic [COL_BITS-1:0] mem_q [NUM_COLS];
   logic [COL_BITS-1:0] rdata_q;

   // write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/column_frame_buffer.sv
// ---------------------------------------------------------------------------
// column_frame_buffer
// Triple-buffered store of per-column ray-cast results. The host assembles
// WORDS_PER_COL 16-bit Avalon words into one entry per column; a finished
// frame waits as "pending" and is promoted to the read bank at the next
// frame_boundary. The pixel side reads entries with 1-cycle latency.
//   clk, reset      : clock, asynchronous active-high reset
//   chipselect/write/read/address/writedata/readdata : Avalon slave
//                     (0=DATA, 1=CTRL, 2=STATUS, 3=reserved)
//   frame_boundary  : 1-cycle pulse at start of vblank
//   rd_en, rd_col   : pixel-side read request
//   rd_data         : entry from the read bank, 1 cycle after rd_en
//   rd_frame_valid  : read bank holds a complete frame
// ---------------------------------------------------------------------------
module column_frame_buffer
   import column_buf_pkg::*;
#(
   parameter  int NUM_COLS      = 640,
   parameter  int WORDS_PER_COL = 4,
   parameter  int DROP_CNT_W    = 8,
   localparam int COL_IDX_W     = $clog2(NUM_COLS),
   localparam int COL_BITS      = 16 * WORDS_PER_COL
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 chipselect,
   input  logic                 write,
   input  logic                 read,
   input  logic [1:0]           address,
   input  logic [15:0]          writedata,
   output logic [15:0]          readdata,
   input  logic                 frame_boundary,
   input  logic                 rd_en,
   input  logic [COL_IDX_W-1:0] rd_col,
   output logic [COL_BITS-1:0]  rd_data,
   output logic                 rd_frame_valid
);

   localparam int WIDX_W = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
   localparam int SHD_W  = 16 * (WORDS_PER_COL - 1);

   buf_idx_t                rd_buf_q,   rd_buf_d;
   buf_idx_t                wr_buf_q,   wr_buf_d;
   buf_idx_t                pend_buf_q, pend_buf_d;
   logic                    pending_q,  pending_d;
   logic                    valid_q,    valid_d;
   logic [COL_IDX_W-1:0]    wr_col_q,   wr_col_d;
   logic [WIDX_W-1:0]       word_idx_q, word_idx_d;
   logic [SHD_W-1:0]        shadow_q,   shadow_d;
   logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [15:0]             readdata_q, readdata_d;
   buf_idx_t                rd_sel_q,   rd_sel_d;
   logic                    rd_zero_q,  rd_zero_d;

   logic                    data_wr_s;
   logic                    ctrl_wr_s;
   logic                    last_word_s;
   logic                    frame_done_s;
   logic                    drop_inc_s;
   logic                    rd_oob_s;
   logic [COL_IDX_W-1:0]    rd_addr_s;
   logic [COL_BITS-1:0]     bank_wdata_s;
   logic [15:0]             status_s;
   logic [COL_BITS-1:0]     bank_rdata_s [3];
   logic [COL_BITS-1:0]     rd_mux_s;

   // Avalon decode and column/frame completion detection
   always_comb begin
      data_wr_s    = chipselect && write && (address == ADDR_DATA);
      ctrl_wr_s    = chipselect && write && (address == ADDR_CTRL);
      last_word_s  = data_wr_s && (word_idx_q == WIDX_W'(WORDS_PER_COL - 1));
      frame_done_s = last_word_s && (wr_col_q == COL_IDX_W'(NUM_COLS - 1));
      bank_wdata_s = {writedata, shadow_q};
      // widened compare so a power-of-two NUM_COLS does not wrap to zero
      rd_oob_s     = ({1'b0, rd_col} >= (COL_IDX_W + 1)'(NUM_COLS));
      rd_addr_s    = rd_oob_s ? {COL_IDX_W{1'b0}} : rd_col;
      status_s     = {8'(drop_cnt_q), pending_q, valid_q, 2'(word_idx_q), 4'b0000};
   end

   // Entry assembly: shadow words, word index and write column
   always_comb begin
      word_idx_d = word_idx_q;
      wr_col_d   = wr_col_q;
      shadow_d   = shadow_q;
      if (ctrl_wr_s && writedata[CTRL_RESYNC_BIT]) begin
         word_idx_d = {WIDX_W{1'b0}};
         wr_col_d   = {COL_IDX_W{1'b0}};
      end else if (data_wr_s) begin
         if (last_word_s) begin
            word_idx_d = {WIDX_W{1'b0}};
            wr_col_d   = frame_done_s ? {COL_IDX_W{1'b0}} : wr_col_q + COL_IDX_W'(1);
         end else begin
            for (int i = 0; i < WORDS_PER_COL - 1; i++) begin
               if (word_idx_q == WIDX_W'(i)) begin
                  shadow_d[16*i +: 16] = writedata;
               end else begin
                  shadow_d[16*i +: 16] = shadow_q[16*i +: 16];
               end
            end
            word_idx_d = word_idx_q + WIDX_W'(1);
         end
      end else begin
         word_idx_d = word_idx_q;
      end
   end

   // Bank rotation between read, write and pending roles
   always_comb begin
      rd_buf_d   = rd_buf_q;
      wr_buf_d   = wr_buf_q;
      pend_buf_d = pend_buf_q;
      pending_d  = pending_q;
      valid_d    = valid_q;
      drop_inc_s = 1'b0;
      if (frame_done_s && frame_boundary) begin
         // finished frame goes straight to display; an older pending frame is lost
         rd_buf_d   = wr_buf_q;
         wr_buf_d   = rd_buf_q;
         pend_buf_d = third_buf(rd_buf_q, wr_buf_q);
         pending_d  = 1'b0;
         valid_d    = 1'b1;
         drop_inc_s = pending_q;
      end else if (frame_done_s) begin
         // writer moves to the free bank (the old pending one if it existed)
         pend_buf_d = wr_buf_q;
         wr_buf_d   = third_buf(rd_buf_q, wr_buf_q);
         pending_d  = 1'b1;
         drop_inc_s = pending_q;
      end else if (frame_boundary && pending_q) begin
         rd_buf_d   = pend_buf_q;
         pend_buf_d = rd_buf_q;
         pending_d  = 1'b0;
         valid_d    = 1'b1;
      end else begin
         pending_d  = pending_q;
      end
   end

   // Saturating dropped-frame counter
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (ctrl_wr_s && writedata[CTRL_CLRDROP_BIT]) begin
         drop_cnt_d = {DROP_CNT_W{1'b0}};
      end else if (drop_inc_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Avalon read data, one cycle after read
   always_comb begin
      readdata_d = readdata_q;
      if (chipselect && read) begin
         case (address)
            ADDR_DATA:   readdata_d = 16'(wr_col_q);
            ADDR_STATUS: readdata_d = status_s;
            default:     readdata_d = 16'h0000;
         endcase
      end else begin
         readdata_d = readdata_q;
      end
   end

   // Pixel read bookkeeping: remember which bank was read and whether out of range
   always_comb begin
      rd_sel_d  = rd_sel_q;
      rd_zero_d = rd_zero_q;
      if (rd_en) begin
         rd_sel_d  = rd_buf_q;
         rd_zero_d = rd_oob_s;
      end else begin
         rd_zero_d = rd_zero_q;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_buf_q   <= 2'd0;
         wr_buf_q   <= 2'd1;
         pend_buf_q <= 2'd2;
         pending_q  <= 1'b0;
         valid_q    <= 1'b0;
         wr_col_q   <= {COL_IDX_W{1'b0}};
         word_idx_q <= {WIDX_W{1'b0}};
         shadow_q   <= {SHD_W{1'b0}};
         drop_cnt_q <= {DROP_CNT_W{1'b0}};
         readdata_q <= 16'h0000;
         rd_sel_q   <= 2'd0;
         rd_zero_q  <= 1'b1;
      end else begin
         rd_buf_q   <= rd_buf_d;
         wr_buf_q   <= wr_buf_d;
         pend_buf_q <= pend_buf_d;
         pending_q  <= pending_d;
         valid_q    <= valid_d;
         wr_col_q   <= wr_col_d;
         word_idx_q <= word_idx_d;
         shadow_q   <= shadow_d;
         drop_cnt_q <= drop_cnt_d;
         readdata_q <= readdata_d;
         rd_sel_q   <= rd_sel_d;
         rd_zero_q  <= rd_zero_d;
      end
   end

   // Each bank is read only while it is the read bank, so a bank is never
   // read and written in the same cycle.
   for (genvar g = 0; g < 3; g++) begin : g_bank
      column_bank #(
         .NUM_COLS (NUM_COLS),
         .COL_BITS (COL_BITS),
         .ADDR_W   (COL_IDX_W)
      ) u_bank (
         .clk   (clk),
         .we    (last_word_s && (wr_buf_q == buf_idx_t'(g))),
         .waddr (wr_col_q),
         .wdata (bank_wdata_s),
         .re    (rd_en && (rd_buf_q == buf_idx_t'(g))),
         .raddr (rd_addr_s),
         .rdata (bank_rdata_s[g])
      );
   end

   // Select the bank that was the read bank when the request was issued
   always_comb begin
      case (rd_sel_q)
         2'd0:    rd_mux_s = bank_rdata_s[0];
         2'd1:    rd_mux_s = bank_rdata_s[1];
         2'd2:    rd_mux_s = bank_rdata_s[2];
         default: rd_mux_s = {COL_BITS{1'b0}};
      endcase
   end

   assign rd_data        = rd_zero_q ? {COL_BITS{1'b0}} : rd_mux_s;
   assign readdata       = readdata_q;
   assign rd_frame_valid = valid_q;

endmodule
